// File: rtl/ropuf_sequencer_if.sv
// Handshake and sequencing bundle between key-generation control (master) and
// the RO-PUF sequencer (slave), plus the round/count bus to the response path.
interface ropuf_sequencer_if;
  logic       start;
  logic       abort;
  logic [0:3] round;
  logic [0:7] count;
  logic       cnt_clear;
  logic       ro_enable;
  logic       busy;
  logic       done;
  logic       key_valid;

  modport master (
    output start, abort,
    input  round, count, cnt_clear, ro_enable, busy, done, key_valid
  );

  modport slave (
    input  start, abort,
    output round, count, cnt_clear, ro_enable, busy, done, key_valid
  );
endinterface

// File: rtl/ropuf_sequencer.sv
// Steps 16 RO-pair rounds of WINDOW+1 cycles each, gating/clearing the RO
// counters so the response register captures one bit per round.
module ropuf_sequencer #(
  parameter int WINDOW = 250
) (
  input logic               clk,
  input logic               Reset_n,
  ropuf_sequencer_if.slave  bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT   = 8'(WINDOW);
  localparam logic [7:0] EN_LAST    = 8'(WINDOW - 1);
  localparam logic [3:0] LAST_ROUND = 4'd15;
  // Park values: neither the clear (0/0) nor the sample (count==WINDOW) point.
  localparam logic [3:0] PARK_ROUND = 4'hf;
  localparam logic [7:0] PARK_CNT   = 8'hff;

  state_t     state_q;
  logic [0:3] round_q;
  logic [0:7] count_q;
  logic       cnt_clear_q;
  logic       ro_enable_q;
  logic       busy_q;
  logic       done_q;
  logic       key_valid_q;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      round_q     <= PARK_ROUND;
      count_q     <= PARK_CNT;
      cnt_clear_q <= 1'b0;
      ro_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking default; a later assignment in the same cycle wins,
      // which makes done a single-cycle pulse without extra logic.
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.abort) begin
            key_valid_q <= 1'b0;
          end else if (bus.start) begin
            state_q     <= S_RUN;
            round_q     <= 4'd0;
            count_q     <= 8'd0;
            cnt_clear_q <= 1'b1;
            ro_enable_q <= 1'b0;
            busy_q      <= 1'b1;
            key_valid_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            state_q     <= S_IDLE;
            round_q     <= PARK_ROUND;
            count_q     <= PARK_CNT;
            cnt_clear_q <= 1'b0;
            ro_enable_q <= 1'b0;
            busy_q      <= 1'b0;
            key_valid_q <= 1'b0;
          end else if (count_q == LAST_CNT) begin
            if (round_q == LAST_ROUND) begin
              state_q     <= S_IDLE;
              round_q     <= PARK_ROUND;
              count_q     <= PARK_CNT;
              cnt_clear_q <= 1'b0;
              ro_enable_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              key_valid_q <= 1'b1;
            end else begin
              round_q     <= round_q + 4'd1;
              count_q     <= 8'd0;
              cnt_clear_q <= 1'b1;
              ro_enable_q <= 1'b0;
            end
          end else begin
            count_q     <= count_q + 8'd1;
            cnt_clear_q <= 1'b0;
            // Enable drops for the sample cycle so the comparator is frozen.
            ro_enable_q <= (count_q != EN_LAST);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.round     = round_q;
  assign bus.count     = count_q;
  assign bus.cnt_clear = cnt_clear_q;
  assign bus.ro_enable = ro_enable_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.key_valid = key_valid_q;

endmodule

// File: doc/ropuf_sequencer.md
# ropuf_sequencer

Sequencing controller for the RO-PUF response path. On a start request it steps through 16 ring-oscillator pair rounds, driving `round` and `count` to the 16-bit response register and gating and clearing the RO frequency counters, so that one response bit is captured per round. When the last bit is captured it reports completion. It sits between the key-generation control logic and the RO array, pair mux, comparator and response register.

## Interface
Parameters:
- `WINDOW`, default 250: count value at which the response register samples. Legal range is 2..254. It must equal the response register's sample constant.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one full 16-round measurement; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; returns the block to IDLE.
- `round`  out  [0:3]  current round / RO pair select; drives the response register and pair mux.
- `count`  out  [0:7]  cycle index within the round; drives the response register.
- `cnt_clear`  out  1  clears the RO frequency counters.
- `ro_enable`  out  1  enables the selected RO pair and its counters.
- `busy`  out  1  high while a measurement is in progress.
- `done`  out  1  one-cycle pulse when all 16 bits are captured.
- `key_valid`  out  1  level signal; the response register holds a complete 16-bit response.

## Operation
- Two states: IDLE and RUN.
- IDLE (park state):
  - `round`=15, `count`=255. This value neither clears the response register (which clears on round 0 / count 0) nor samples it (count==WINDOW), so the captured response is held.
  - `cnt_clear`=0, `ro_enable`=0, `busy`=0.
- IDLE -> RUN when `start`=1 and `abort`=0. The next cycle shows `round`=0, `count`=0.
- RUN, per round:
  - `count` steps 0, 1, …, WINDOW, incrementing by 1 per cycle.
  - `cnt_clear`=1 only when `count`==0. In round 0 this same cycle also clears the response register.
  - `ro_enable`=1 for 1 <= `count` <= WINDOW-1.
  - `ro_enable`=0 at `count`==WINDOW, which freezes the counters so the comparator output is stable when the register samples.
- After the `count`==WINDOW cycle:
  - If `round`<15: `round` increments and `count` returns to 0.
  - If `round`==15: go to IDLE with the park values, pulse `done`=1 for one cycle, and set `key_valid`=1.
- `key_valid`:
  - Cleared in the first RUN cycle of a new measurement, on `abort`, or on reset.
  - Otherwise holds.
- `abort`=1 in RUN: the next cycle is IDLE with park values, `key_valid`=0 and no `done`.
- `abort` in IDLE has no effect other than clearing `key_valid`.
- `start` while in RUN is ignored; there is no queuing.
- `start` and `abort` asserted together in IDLE: abort wins and the block stays in IDLE.
- The `round` counter never wraps inside RUN. The 15 -> park transition is the only exit apart from abort and reset.

## Timing
- Reset (asynchronous assert on `Reset_n`=0):
  - State = IDLE, `round`=15, `count`=255.
  - `cnt_clear`=0, `ro_enable`=0, `busy`=0, `done`=0, `key_valid`=0.
  - Release is synchronous to `clk`. `Reset_n` low mid-RUN immediately forces all of these values.
- Measurement timeline (cycle 0 = `start` sampled in IDLE):
  - Latency from `start` to `busy`=1 and `round`/`count`=0/0 is one cycle.
  - Each round lasts WINDOW+1 cycles (251 at default).
  - RUN occupies cycles 1 .. 16·(WINDOW+1), i.e. 1..4016 at default.
  - `done` and `key_valid` rise in cycle 16·(WINDOW+1)+1 (4017 at default).
- Round r (0-based) sample cycle is 1 + r·(WINDOW+1) + WINDOW. The response register captures bit r at the end of that cycle.
- A new `start` is accepted in the same cycle that `done`=1, since the block is already in IDLE.
- All outputs are registered; none depends combinationally on `start` or `abort`.

## Test plan
- Reset: hold `Reset_n`=0 -> `round`=15, `count`=255, all flags 0. Assert `Reset_n`=0 at cycle 600 of a run -> same values immediately, no `done`.
- Full run (default WINDOW): `start` pulse at cycle 0 -> `round`/`count`=0/0 in cycle 1 with `cnt_clear`=1; `count`=250 first in cycle 251; `round`=1, `count`=0 in cycle 252; `done`=1 only in cycle 4017; `key_valid`=1 thereafter.
- Enable window: in round 3, `ro_enable`=1 exactly when `count` is 1..249; `cnt_clear`=1 only when `count`=0; exactly 16 cycles with `count`==250 per run.
- End-to-end with the response register and a comparator stub driving bit pattern 0xA5C3 -> register reads 0xA5C3 when `done`=1, and is unchanged 1000 cycles later in IDLE.
- Abort: `abort` at cycle 1000 -> IDLE park values in cycle 1001, `key_valid`=0, no `done`; `start` and `abort` together in IDLE -> stays IDLE.
- `start` re-asserted at cycles 50 and 3000 during RUN -> ignored, `done` still only in cycle 4017; `start` in the `done` cycle -> new run begins the next cycle, with `key_valid` falling in that cycle.
